// File: rtl/rv32_mem_pkg.sv
// rtl/rv32_mem_pkg.sv - shared FUNC3 encodings and MEM-stage FSM state type
package rv32_mem_pkg;

    // Load FUNC3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store FUNC3 encodings
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte-lane formatting and legality check for data memory accesses
//
// Purely combinational helper for dmem_access_ctrl.
// Ports:
//   mem_read_i, mem_write_i : access type of the instruction in MEM
//   func3_i, lane_i         : size/sign and ADDR[1:0] of the instruction in MEM
//   wdata_i                 : raw store data (rs2)
//   ld_func3_i, ld_lane_i   : size/sign and lane of the access being completed
//   rdata_i                 : raw word returned by the memory
//   legal_o                 : access requested and legal
//   fault_o                 : access requested but illegal
//   st_wdata_o, st_be_o     : lane-replicated store data and byte enables
//   ld_data_o               : extracted and extended load result
module dmem_lane_align
    import rv32_mem_pkg::*;
(
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [2:0]  func3_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] wdata_i,
    input  logic [2:0]  ld_func3_i,
    input  logic [1:0]  ld_lane_i,
    input  logic [31:0] rdata_i,
    output logic        legal_o,
    output logic        fault_o,
    output logic [31:0] st_wdata_o,
    output logic [3:0]  st_be_o,
    output logic [31:0] ld_data_o
);

    logic       active;
    logic       size_ok;
    logic       align_ok;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign active = mem_read_i | mem_write_i;

    always_comb begin
        size_ok = 1'b0;
        if (mem_read_i) begin
            case (func3_i)
                F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: size_ok = 1'b1;
                default:                             size_ok = 1'b0;
            endcase
        end else if (mem_write_i) begin
            case (func3_i)
                F3_SB, F3_SH, F3_SW: size_ok = 1'b1;
                default:             size_ok = 1'b0;
            endcase
        end
    end

    // FUNC3[1:0] encodes the access size for both loads and stores.
    always_comb begin
        case (func3_i[1:0])
            2'b00:   align_ok = 1'b1;
            2'b01:   align_ok = ~lane_i[0];
            2'b10:   align_ok = (lane_i == 2'b00);
            default: align_ok = 1'b0;
        endcase
    end

    assign legal_o = active & ~(mem_read_i & mem_write_i) & size_ok & align_ok;
    assign fault_o = active & ~legal_o;

    always_comb begin
        st_wdata_o = wdata_i;
        st_be_o    = 4'b1111;
        if (!mem_read_i) begin
            case (func3_i[1:0])
                2'b00: begin
                    st_wdata_o = {4{wdata_i[7:0]}};
                    st_be_o    = 4'b0001 << lane_i;
                end
                2'b01: begin
                    st_wdata_o = {2{wdata_i[15:0]}};
                    st_be_o    = 4'b0011 << lane_i;
                end
                default: begin
                    st_wdata_o = wdata_i;
                    st_be_o    = 4'b1111;
                end
            endcase
        end
    end

    always_comb begin
        case (ld_lane_i)
            2'd0:    ld_byte = rdata_i[7:0];
            2'd1:    ld_byte = rdata_i[15:8];
            2'd2:    ld_byte = rdata_i[23:16];
            default: ld_byte = rdata_i[31:24];
        endcase
        ld_half = ld_lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        case (ld_func3_i)
            F3_LB:   ld_data_o = {{24{ld_byte[7]}}, ld_byte};
            F3_LBU:  ld_data_o = {24'd0, ld_byte};
            F3_LH:   ld_data_o = {{16{ld_half[15]}}, ld_half};
            F3_LHU:  ld_data_o = {16'd0, ld_half};
            default: ld_data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - MEM-stage data memory access sequencer with pipeline stall
//
// Ports:
//   CLK, RST            : clock, synchronous active-high reset
//   MEM_READ, MEM_WRITE : load / store in MEM stage
//   FUNC3, ADDR, WDATA  : access size/sign, byte address, store data
//   STALL               : freeze PC and IF/ID, ID/EX, EX/MEM registers
//   RDATA               : registered, formatted load result for MEM/WB
//   FAULT               : one-cycle pulse on illegal or timed-out access
//   DM_REQ, DM_WE, DM_ADDR, DM_WDATA, DM_BE : memory request side
//   DM_RDATA, DM_ACK    : memory response side
module dmem_access_ctrl
    import rv32_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        MEM_READ,
    input  logic        MEM_WRITE,
    input  logic [2:0]  FUNC3,
    input  logic [31:0] ADDR,
    input  logic [31:0] WDATA,
    output logic        STALL,
    output logic [31:0] RDATA,
    output logic        FAULT,
    output logic        DM_REQ,
    output logic        DM_WE,
    output logic [31:0] DM_ADDR,
    output logic [31:0] DM_WDATA,
    output logic [3:0]  DM_BE,
    input  logic [31:0] DM_RDATA,
    input  logic        DM_ACK
);

    mem_state_e  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        dm_req_q, dm_req_d;
    logic        dm_we_q, dm_we_d;
    logic [31:0] dm_addr_q, dm_addr_d;
    logic [31:0] dm_wdata_q, dm_wdata_d;
    logic [3:0]  dm_be_q, dm_be_d;
    logic [31:0] rdata_q, rdata_d;
    logic        fault_q, fault_d;
    logic [2:0]  func3_q, func3_d;
    logic [1:0]  lane_q, lane_d;
    logic        is_load_q, is_load_d;

    logic        acc_legal;
    logic        acc_fault;
    logic [31:0] st_wdata;
    logic [3:0]  st_be;
    logic [31:0] ld_data;
    logic        tmo_hit;
    logic        stall_c;
    logic        idle_fault_c;

    // Store formatting and legality use the live EX/MEM inputs; load extraction
    // uses the size/lane latched at request time so it cannot drift mid-access.
    dmem_lane_align u_lane_align (
        .mem_read_i  (MEM_READ),
        .mem_write_i (MEM_WRITE),
        .func3_i     (FUNC3),
        .lane_i      (ADDR[1:0]),
        .wdata_i     (WDATA),
        .ld_func3_i  (func3_q),
        .ld_lane_i   (lane_q),
        .rdata_i     (DM_RDATA),
        .legal_o     (acc_legal),
        .fault_o     (acc_fault),
        .st_wdata_o  (st_wdata),
        .st_be_o     (st_be),
        .ld_data_o   (ld_data)
    );

    // cnt_q holds the number of ACCESS cycles already spent without ack, so
    // the current cycle is the TIMEOUT-th one when cnt_q == TIMEOUT-1.
    assign tmo_hit = (TIMEOUT != 0) && (cnt_q == (TIMEOUT - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dm_req_q   <= 1'b0;
            dm_we_q    <= 1'b0;
            dm_addr_q  <= '0;
            dm_wdata_q <= '0;
            dm_be_q    <= '0;
            rdata_q    <= '0;
            fault_q    <= 1'b0;
            func3_q    <= '0;
            lane_q     <= '0;
            is_load_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dm_req_q   <= dm_req_d;
            dm_we_q    <= dm_we_d;
            dm_addr_q  <= dm_addr_d;
            dm_wdata_q <= dm_wdata_d;
            dm_be_q    <= dm_be_d;
            rdata_q    <= rdata_d;
            fault_q    <= fault_d;
            func3_q    <= func3_d;
            lane_q     <= lane_d;
            is_load_q  <= is_load_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        dm_req_d     = dm_req_q;
        dm_we_d      = dm_we_q;
        dm_addr_d    = dm_addr_q;
        dm_wdata_d   = dm_wdata_q;
        dm_be_d      = dm_be_q;
        rdata_d      = rdata_q;
        fault_d      = 1'b0;
        func3_d      = func3_q;
        lane_d       = lane_q;
        is_load_d    = is_load_q;
        stall_c      = 1'b0;
        idle_fault_c = 1'b0;

        case (state_q)
            IDLE: begin
                idle_fault_c = acc_fault;
                if (acc_legal) begin
                    stall_c    = 1'b1;
                    state_d    = ACCESS;
                    cnt_d      = '0;
                    dm_req_d   = 1'b1;
                    dm_we_d    = MEM_WRITE;
                    dm_addr_d  = {ADDR[31:2], 2'b00};
                    dm_wdata_d = st_wdata;
                    dm_be_d    = st_be;
                    func3_d    = FUNC3;
                    lane_d     = ADDR[1:0];
                    is_load_d  = MEM_READ;
                end
            end
            ACCESS: begin
                stall_c = 1'b1;
                // An ack arriving in the final allowed cycle still completes
                // the access rather than faulting.
                if (DM_ACK) begin
                    state_d  = DONE;
                    dm_req_d = 1'b0;
                    if (is_load_q) begin
                        rdata_d = ld_data;
                    end
                end else if (tmo_hit) begin
                    state_d  = DONE;
                    dm_req_d = 1'b0;
                    fault_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            DONE: begin
                // Inputs still show the finished instruction here; going
                // straight to IDLE after this cycle avoids re-issuing it.
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                dm_req_d = 1'b0;
            end
        endcase
    end

    assign STALL    = stall_c;
    assign RDATA    = rdata_q;
    // Illegal accesses fault in their IDLE cycle; timeouts fault in DONE,
    // alongside the instruction as it leaves the MEM stage.
    assign FAULT    = idle_fault_c | fault_q;
    assign DM_REQ   = dm_req_q;
    assign DM_WE    = dm_we_q;
    assign DM_ADDR  = dm_addr_q;
    assign DM_WDATA = dm_wdata_q;
    assign DM_BE    = dm_be_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - randomized self-checking bench for dmem_access_ctrl
module tb_dmem_access_ctrl;

    localparam int unsigned TMO = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic        MEM_READ, MEM_WRITE;
    logic [2:0]  FUNC3;
    logic [31:0] ADDR, WDATA;
    logic        STALL;
    logic [31:0] RDATA;
    logic        FAULT;
    logic        DM_REQ, DM_WE;
    logic [31:0] DM_ADDR, DM_WDATA;
    logic [3:0]  DM_BE;
    logic [31:0] DM_RDATA;
    logic        DM_ACK;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] mdl_rdata = 32'd0;

    dmem_access_ctrl #(.TIMEOUT(TMO)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .MEM_READ (MEM_READ),
        .MEM_WRITE(MEM_WRITE),
        .FUNC3    (FUNC3),
        .ADDR     (ADDR),
        .WDATA    (WDATA),
        .STALL    (STALL),
        .RDATA    (RDATA),
        .FAULT    (FAULT),
        .DM_REQ   (DM_REQ),
        .DM_WE    (DM_WE),
        .DM_ADDR  (DM_ADDR),
        .DM_WDATA (DM_WDATA),
        .DM_BE    (DM_BE),
        .DM_RDATA (DM_RDATA),
        .DM_ACK   (DM_ACK)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic bit ref_legal(input bit rd, input bit wr, input logic [2:0] f3,
                                     input logic [31:0] a);
        int unsigned sz;
        logic [1:0]  szc;
        if (rd == wr) return 1'b0;
        if (rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
        if (wr && f3 > 3'd2) return 1'b0;
        szc = f3[1:0];
        sz  = 1 << szc;
        return (a % sz) == 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] w);
        int unsigned lane;
        logic [31:0] v;
        lane = a % 4;
        if (f3 == 3'd2) return w;
        if (f3 == 3'd0 || f3 == 3'd4) begin
            v = (w >> (8 * lane)) & 32'hFF;
            if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
        end else begin
            v = (w >> (16 * (lane / 2))) & 32'hFFFF;
            if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
        if (f3 == 3'd0) return (d & 32'hFF) * 32'h01010101;
        if (f3 == 3'd1) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] ref_be(input bit rd, input logic [2:0] f3, input logic [31:0] a);
        if (rd || f3 == 3'd2) return 32'hF;
        if (f3 == 3'd0) return 32'd1 << (a % 4);
        return 32'd3 << (a % 4);
    endfunction

    // Called #1 after a posedge with the DUT in IDLE. ack_cyc is the ACCESS
    // cycle (1-based) on which the memory acks; 0 means it never acks.
    task automatic access(input string tag, input bit rd, input bit wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input int ack_cyc,
                          input logic [31:0] word);
        bit legal, tmo, done;
        int n_exp, n_stall;
        legal = ref_legal(rd, wr, f3, a);
        MEM_READ = rd; MEM_WRITE = wr; FUNC3 = f3; ADDR = a; WDATA = wd;
        DM_ACK = 1'b0;
        @(negedge CLK);
        if (!legal) begin
            check({tag, " idle fault"}, 32'(FAULT), 32'(rd | wr));
            check({tag, " idle stall"}, 32'(STALL), 32'd0);
            check({tag, " idle req"}, 32'(DM_REQ), 32'd0);
            @(posedge CLK); #1;
            MEM_READ = 1'b0; MEM_WRITE = 1'b0;
            @(negedge CLK);
            check({tag, " no req after"}, 32'(DM_REQ), 32'd0);
            check({tag, " rdata held"}, RDATA, mdl_rdata);
            @(posedge CLK); #1;
            return;
        end
        check({tag, " idle stall"}, 32'(STALL), 32'd1);
        check({tag, " idle fault"}, 32'(FAULT), 32'd0);
        tmo   = !(ack_cyc >= 1 && ack_cyc <= int'(TMO));
        n_exp = tmo ? int'(TMO) : ack_cyc;
        n_stall = 1;
        done = 1'b0;
        @(posedge CLK); #1;
        for (int k = 1; k <= int'(TMO) + 2 && !done; k++) begin
            DM_ACK   = (k == ack_cyc);
            DM_RDATA = (k == ack_cyc) ? word : $urandom;
            @(negedge CLK);
            if (!STALL) begin
                done = 1'b1;
            end else begin
                n_stall++;
                check({tag, " req"}, 32'(DM_REQ), 32'd1);
                if (k == 1) begin
                    check({tag, " addr"}, DM_ADDR, a & 32'hFFFFFFFC);
                    check({tag, " be"}, 32'(DM_BE), ref_be(rd, f3, a));
                    check({tag, " we"}, 32'(DM_WE), 32'(wr));
                    if (wr) check({tag, " wdata"}, DM_WDATA, ref_wdata(f3, wd));
                end
                @(posedge CLK); #1;
            end
        end
        check({tag, " done reached"}, 32'(done), 32'd1);
        check({tag, " stall cycles"}, 32'(n_stall), 32'(1 + n_exp));
        check({tag, " done req"}, 32'(DM_REQ), 32'd0);
        check({tag, " done fault"}, 32'(FAULT), 32'(tmo));
        if (rd && !tmo) mdl_rdata = ref_load(f3, a, word);
        check({tag, " rdata"}, RDATA, mdl_rdata);
        // Acks outside ACCESS must be ignored.
        DM_ACK = 1'($urandom_range(0, 1));
        DM_RDATA = $urandom;
        @(posedge CLK); #1;
        DM_ACK = 1'b0;
        MEM_READ = 1'b0; MEM_WRITE = 1'b0;
    endtask

    initial begin
        RST = 1'b1; MEM_READ = 1'b0; MEM_WRITE = 1'b0; FUNC3 = 3'd0;
        ADDR = 32'd0; WDATA = 32'd0; DM_RDATA = 32'd0; DM_ACK = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        check("rst stall", 32'(STALL), 32'd0);
        check("rst rdata", RDATA, 32'd0);
        check("rst fault", 32'(FAULT), 32'd0);
        check("rst req", 32'(DM_REQ), 32'd0);
        check("rst we", 32'(DM_WE), 32'd0);
        check("rst addr", DM_ADDR, 32'd0);
        check("rst wdata", DM_WDATA, 32'd0);
        check("rst be", 32'(DM_BE), 32'd0);
        @(posedge CLK); #1;
        RST = 1'b0;

        access("lw", 1, 0, 3'd2, 32'h100, 32'h0, 3, 32'hDEADBEEF);
        check("lw rdata const", RDATA, 32'hDEADBEEF);
        access("lb", 1, 0, 3'd0, 32'h203, 32'h0, 1, 32'h80FF1234);
        check("lb rdata const", RDATA, 32'hFFFFFF80);
        access("lbu", 1, 0, 3'd4, 32'h203, 32'h0, 2, 32'h80FF1234);
        check("lbu rdata const", RDATA, 32'h00000080);
        access("sh", 0, 1, 3'd1, 32'h12, 32'h0000ABCD, 1, 32'h0);
        access("lw misaligned", 1, 0, 3'd2, 32'h102, 32'h0, 1, 32'h0);
        access("timeout", 1, 0, 3'd2, 32'h300, 32'h0, 0, 32'h0);
        check("timeout rdata kept", RDATA, 32'h00000080);
        access("both", 1, 1, 3'd2, 32'h300, 32'h0, 1, 32'h0);
        access("bad load f3", 1, 0, 3'd3, 32'h300, 32'h0, 1, 32'h0);
        access("bad store f3", 0, 1, 3'd4, 32'h300, 32'h0, 1, 32'h0);

        for (int i = 0; i < 200; i++) begin
            int unsigned sel;
            bit rd, wr;
            logic [2:0] f3;
            logic [2:0] legal_f3 [5];
            legal_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
            sel = $urandom_range(0, 9);
            rd = (sel == 0) || (sel >= 2 && sel <= 5);
            wr = (sel == 0) || (sel >= 6);
            if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
            else f3 = legal_f3[$urandom_range(0, wr ? 2 : 4)];
            access("rand", rd, wr, f3, $urandom, $urandom, int'($urandom_range(0, 5)), $urandom);
        end

        access("pre-rst lw", 1, 0, 3'd2, 32'h40, 32'h0, 1, 32'h13572468);
        MEM_READ = 1'b1; FUNC3 = 3'd2; ADDR = 32'h44; DM_ACK = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        @(negedge CLK);
        check("rst-acc req before", 32'(DM_REQ), 32'd1);
        RST = 1'b1; MEM_READ = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        check("rst-acc stall", 32'(STALL), 32'd0);
        check("rst-acc req", 32'(DM_REQ), 32'd0);
        check("rst-acc rdata", RDATA, 32'd0);
        check("rst-acc addr", DM_ADDR, 32'd0);
        check("rst-acc be", 32'(DM_BE), 32'd0);
        check("rst-acc we", 32'(DM_WE), 32'd0);
        DM_ACK = 1'b1; DM_RDATA = 32'hCAFEF00D;
        @(posedge CLK); #1;
        DM_ACK = 1'b0;
        @(negedge CLK);
        check("late ack rdata", RDATA, 32'd0);
        check("late ack req", 32'(DM_REQ), 32'd0);
        check("late ack stall", 32'(STALL), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
